// File: rtl/pkg_system_mdr.sv
// Shared definitions for the MDR iterative engine: operation codes,
// FSM state encoding and the default operand width.
package pkg_system_mdr;

  localparam int DEFAULT_DW = 16;

  // Operation codes; code 3 is reserved and reported as an error.
  typedef enum logic [1:0] {
    OP_MULT = 2'd0,
    OP_DIV  = 2'd1,
    OP_ROOT = 2'd2
  } mdr_op_e;

  localparam logic [1:0] OP_INVALID = 2'd3;

  // Engine FSM encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mdr_step_unit.sv
// One radix-2 iteration of multiply, restoring divide or digit-by-digit
// square root. Purely combinational; the engine registers the results.
//   w : accumulator (product / quotient / root), shifted left each step
//   r : partial remainder (DIV, ROOT)
//   s : operand shift register feeding one (MULT/DIV) or two (ROOT) bits
module mdr_step_unit
  import pkg_system_mdr::*;
#(
  parameter int DW = DEFAULT_DW
) (
  input  logic [1:0]      op_i,
  input  logic [DW-1:0]   x_i,
  input  logic [DW-1:0]   y_i,
  input  logic [2*DW-1:0] w_i,
  input  logic [DW+1:0]   r_i,
  input  logic [DW-1:0]   s_i,
  output logic [2*DW-1:0] w_o,
  output logic [DW+1:0]   r_o,
  output logic [DW-1:0]   s_o
);

  logic [DW+1:0] pre;
  logic [DW+1:0] trial;

  // Select and evaluate the iteration for the active operation.
  always_comb begin
    w_o   = w_i;
    r_o   = r_i;
    s_o   = s_i;
    pre   = '0;
    trial = '0;
    case (op_i)
      OP_MULT: begin
        // MSB-first shift-add: multiplier bits come out of s.
        s_o = {s_i[DW-2:0], 1'b0};
        w_o = {w_i[2*DW-2:0], 1'b0} +
              (s_i[DW-1] ? {{DW{1'b0}}, x_i} : {(2*DW){1'b0}});
      end
      OP_DIV: begin
        // Bring down the next dividend bit, subtract divisor if it fits.
        pre   = {1'b0, r_i[DW-1:0], s_i[DW-1]};
        trial = {2'b00, y_i};
        s_o   = {s_i[DW-2:0], 1'b0};
        if (pre >= trial) begin
          r_o = pre - trial;
          w_o = {w_i[2*DW-2:0], 1'b1};
        end else begin
          r_o = pre;
          w_o = {w_i[2*DW-2:0], 1'b0};
        end
      end
      OP_ROOT: begin
        // Bring down two radicand bits, try subtracting 4*root+1.
        pre   = {r_i[DW-1:0], s_i[DW-1:DW-2]};
        trial = {w_i[DW-1:0], 2'b01};
        s_o   = {s_i[DW-3:0], 2'b00};
        if (pre >= trial) begin
          r_o = pre - trial;
          w_o = {w_i[2*DW-2:0], 1'b1};
        end else begin
          r_o = pre;
          w_o = {w_i[2*DW-2:0], 1'b0};
        end
      end
      default: begin
        w_o = w_i;
      end
    endcase
  end

endmodule

// File: rtl/mdr_seq_engine.sv
// Iterative multiply/divide/root engine. Accepts a request in IDLE,
// runs one step per clock in RUN, and pulses o_done for one cycle in DONE.
// Exceptions (divide by zero, invalid op) skip RUN and finish at once.
// All outputs are decoded from registers; nothing passes through from inputs.
module mdr_seq_engine
  import pkg_system_mdr::*;
#(
  parameter int DW = DEFAULT_DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  input  logic [DW-1:0]   i_data_X,
  input  logic [DW-1:0]   i_data_Y,
  output logic            o_busy,
  output logic            o_done,
  output logic [2*DW-1:0] o_result,
  output logic [DW-1:0]   o_remainder,
  output logic            o_error,
  output logic [1:0]      o_dbg_state
);

  localparam int CW = $clog2(DW) + 1;

  logic [1:0]      state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [DW-1:0]   x_q, x_d;
  logic [DW-1:0]   y_q, y_d;
  logic [2*DW-1:0] w_q, w_d;
  logic [DW+1:0]   r_q, r_d;
  logic [DW-1:0]   s_q, s_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*DW-1:0] res_q, res_d;
  logic [DW-1:0]   rem_q, rem_d;
  logic            err_q, err_d;

  logic [2*DW-1:0] step_w;
  logic [DW+1:0]   step_r;
  logic [DW-1:0]   step_s;
  logic [CW-1:0]   last_cnt;

  mdr_step_unit #(.DW(DW)) u_step (
    .op_i (op_q),
    .x_i  (x_q),
    .y_i  (y_q),
    .w_i  (w_q),
    .r_i  (r_q),
    .s_i  (s_q),
    .w_o  (step_w),
    .r_o  (step_r),
    .s_o  (step_s)
  );

  // ROOT needs half as many iterations as MULT/DIV.
  assign last_cnt = (op_q == OP_ROOT) ? CW'(DW/2 - 1) : CW'(DW - 1);

  // Next-state logic: acceptance, iteration and result loading.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    x_d     = x_q;
    y_d     = y_q;
    w_d     = w_q;
    r_d     = r_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    rem_d   = rem_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          op_d  = i_op;
          x_d   = i_data_X;
          y_d   = i_data_Y;
          w_d   = '0;
          r_d   = '0;
          cnt_d = '0;
          s_d   = (i_op == OP_MULT) ? i_data_Y : i_data_X;
          if (i_op == OP_INVALID) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
            res_d   = '0;
            rem_d   = '0;
          end else if (i_op == OP_DIV && i_data_Y == '0) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
            res_d   = '1;
            rem_d   = i_data_X;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        w_d   = step_w;
        r_d   = step_r;
        s_d   = step_s;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == last_cnt) begin
          state_d = ST_DONE;
          err_d   = 1'b0;
          if (op_q == OP_MULT) begin
            res_d = step_w;
            rem_d = '0;
          end else begin
            res_d = {{DW{1'b0}}, step_w[DW-1:0]};
            rem_d = step_r[DW-1:0];
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      r_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      r_q     <= r_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  assign o_busy      = (state_q != ST_IDLE);
  assign o_done      = (state_q == ST_DONE);
  assign o_result    = res_q;
  assign o_remainder = rem_q;
  assign o_error     = err_q;
  assign o_dbg_state = state_q;

endmodule
